// File: rtl/battleship_phase_ctrl.sv
// Game-phase sequencer for battleship: placement, alternating attack turns,
// per-player hit scores and winner detection. Every output is registered.
module battleship_phase_ctrl #(
  parameter int unsigned SHIPS_PER_PLAYER = 5,
  parameter int unsigned HITS_TO_WIN      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       place_valid,
  input  logic       place_ok,
  input  logic       fire_valid,
  input  logic       fire_hit,
  input  logic       fire_repeat,
  output logic [2:0] phase,
  output logic [3:0] ships_left,
  output logic [3:0] p1_hits,
  output logic [3:0] p2_hits,
  output logic       turn_done,
  output logic       reject,
  output logic       game_over
);

  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] P1_PLACE = 3'b000;
  localparam logic [2:0] P2_PLACE = 3'b001;
  localparam logic [2:0] P1_ATK   = 3'b010;
  localparam logic [2:0] P2_ATK   = 3'b011;
  localparam logic [2:0] P1_WIN   = 3'b100;
  localparam logic [2:0] P2_WIN   = 3'b101;

  localparam logic [CNT_W-1:0] SHIPS_INIT = CNT_W'(SHIPS_PER_PLAYER);
  localparam logic [CNT_W-1:0] HITS_GOAL  = CNT_W'(HITS_TO_WIN);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] ships_q, ships_d;
  logic [CNT_W-1:0] p1_hits_q, p1_hits_d;
  logic [CNT_W-1:0] p2_hits_q, p2_hits_d;
  logic             turn_q, turn_d;
  logic             reject_q, reject_d;

  // Next-state and pulse decode; new_game and illegal encodings restart the game
  always_comb begin
    phase_d   = phase_q;
    ships_d   = ships_q;
    p1_hits_d = p1_hits_q;
    p2_hits_d = p2_hits_q;
    turn_d    = 1'b0;
    reject_d  = 1'b0;

    if (new_game) begin
      phase_d   = P1_PLACE;
      ships_d   = SHIPS_INIT;
      p1_hits_d = '0;
      p2_hits_d = '0;
    end else begin
      case (phase_q)
        P1_PLACE, P2_PLACE: begin
          if (place_valid) begin
            if (!place_ok) begin
              reject_d = 1'b1;
            end else if (ships_q == CNT_ONE) begin
              // Last ship: hand placement to P2, or start the attack phase
              turn_d = 1'b1;
              if (phase_q == P1_PLACE) begin
                phase_d = P2_PLACE;
                ships_d = SHIPS_INIT;
              end else begin
                phase_d = P1_ATK;
                ships_d = '0;
              end
            end else begin
              ships_d = ships_q - CNT_ONE;
            end
          end
        end
        P1_ATK: begin
          if (fire_valid) begin
            if (fire_repeat) begin
              reject_d = 1'b1;
            end else if (fire_hit && (p1_hits_q + CNT_ONE) == HITS_GOAL) begin
              p1_hits_d = p1_hits_q + CNT_ONE;
              phase_d   = P1_WIN;
            end else begin
              if (fire_hit) p1_hits_d = p1_hits_q + CNT_ONE;
              phase_d = P2_ATK;
              turn_d  = 1'b1;
            end
          end
        end
        P2_ATK: begin
          if (fire_valid) begin
            if (fire_repeat) begin
              reject_d = 1'b1;
            end else if (fire_hit && (p2_hits_q + CNT_ONE) == HITS_GOAL) begin
              p2_hits_d = p2_hits_q + CNT_ONE;
              phase_d   = P2_WIN;
            end else begin
              if (fire_hit) p2_hits_d = p2_hits_q + CNT_ONE;
              phase_d = P1_ATK;
              turn_d  = 1'b1;
            end
          end
        end
        P1_WIN, P2_WIN: begin
          // Terminal: hold everything until a new game
        end
        default: begin
          phase_d   = P1_PLACE;
          ships_d   = SHIPS_INIT;
          p1_hits_d = '0;
          p2_hits_d = '0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= P1_PLACE;
      ships_q   <= SHIPS_INIT;
      p1_hits_q <= '0;
      p2_hits_q <= '0;
      turn_q    <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      ships_q   <= ships_d;
      p1_hits_q <= p1_hits_d;
      p2_hits_q <= p2_hits_d;
      turn_q    <= turn_d;
      reject_q  <= reject_d;
    end
  end

  assign phase      = phase_q;
  assign ships_left = ships_q;
  assign p1_hits    = p1_hits_q;
  assign p2_hits    = p2_hits_q;
  assign turn_done  = turn_q;
  assign reject     = reject_q;
  assign game_over  = phase_q[2];

endmodule
